// File: rtl/memory_request_unit_pkg.sv
// Shared LSU types: memory op kind and the in-flight tracker entry layout.
package memory_request_unit_pkg;

  // Tag field sized for the widest supported ROB tag; narrower tags are zero-extended.
  localparam int TAG_W_MAX = 32;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } mem_op_t;

  typedef struct packed {
    mem_op_t                op;
    logic [TAG_W_MAX-1:0]   rob_tag;
    logic                   squashed;
  } tracker_entry_t;

  function automatic logic is_live_load(tracker_entry_t e);
    return (e.op == LOAD) && !e.squashed;
  endfunction

endpackage

// File: rtl/memory_request_unit_if.sv
// Memory-side request/response bus between the request unit and the memory system.
interface memory_request_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req_valid;
  logic            mem_req_we;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/memory_request_unit_inflight_tracker.sv
// Circular FIFO of requests awaiting an in-order response, with a squash-all-loads port.
module inflight_tracker
  import memory_request_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  tracker_entry_t         push_entry,
  input  logic                   pop,
  input  logic                   squash_all,
  output tracker_entry_t         head_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int PTR_W = $clog2(DEPTH);

  tracker_entry_t         entries [DEPTH];
  logic [PTR_W-1:0]       head_reg;
  logic [PTR_W-1:0]       tail_reg;
  logic [PTR_W:0]         count_reg;
  logic                   pop_eff;

  // A response with nothing outstanding is a protocol error and is dropped.
  assign pop_eff = pop && (count_reg != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (squash_all) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entries[i].op == LOAD) begin
            entries[i].squashed <= 1'b1;
          end
        end
      end
      // The pushed entry carries its own squash state and overrides the loop above.
      if (push) begin
        entries[tail_reg] <= push_entry;
        tail_reg          <= tail_reg + 1'b1;
      end
      if (pop_eff) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({push, pop_eff})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_entry = entries[head_reg];
  assign count      = count_reg;
  assign empty      = (count_reg == '0);

endmodule

// File: rtl/memory_request_unit.sv
// Issues LSU memory ops onto a valid/ready bus and turns in-order responses into completions.
module memory_request_unit
  import memory_request_unit_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 32,
  parameter int MAX_INFLIGHT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fire_memory_op,
  input  logic                     memory_op_type,
  input  logic [XLEN-1:0]          memory_address,
  input  logic [XLEN-1:0]          memory_data,
  input  logic [ROB_TAG_WIDTH-1:0] memory_rob_tag,
  input  logic                     kill_mem_req,
  input  logic                     flush,
  output logic                     accept,
  memory_request_unit_if.master    mem,
  output logic                     load_succeeded,
  output logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag,
  output logic [XLEN-1:0]          load_data,
  output logic                     store_succeeded,
  output logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t                   state_reg;
  mem_op_t                  req_op_reg;
  logic [XLEN-1:0]          req_addr_reg;
  logic [XLEN-1:0]          req_data_reg;
  logic [ROB_TAG_WIDTH-1:0] req_tag_reg;

  logic                     in_req;
  logic                     handshake;
  logic                     capture;
  logic                     req_is_load;
  mem_op_t                  incoming_op;
  tracker_entry_t           push_entry;
  tracker_entry_t           head_entry;
  logic [CNT_W-1:0]         tracker_count;
  logic                     tracker_empty;

  assign in_req      = (state_reg == REQ);
  assign handshake   = in_req && mem.mem_req_ready;
  assign req_is_load = (req_op_reg == LOAD);
  assign incoming_op = mem_op_t'(memory_op_type);

  // The op being handed off this cycle still occupies a tracker slot in the count.
  assign accept  = (!in_req || mem.mem_req_ready) &&
                   ((tracker_count + CNT_W'(in_req)) < CNT_W'(MAX_INFLIGHT));
  assign capture = fire_memory_op && accept && !kill_mem_req &&
                   !(flush && (incoming_op == LOAD));

  always_comb begin
    push_entry          = '0;
    push_entry.op       = req_op_reg;
    push_entry.rob_tag  = TAG_W_MAX'(req_tag_reg);
    push_entry.squashed = flush && req_is_load;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      req_op_reg   <= LOAD;
      req_addr_reg <= '0;
      req_data_reg <= '0;
      req_tag_reg  <= '0;
    end else begin
      if (capture) begin
        req_op_reg   <= incoming_op;
        req_addr_reg <= memory_address;
        req_data_reg <= memory_data;
        req_tag_reg  <= memory_rob_tag;
      end
      case (state_reg)
        IDLE: begin
          if (capture) state_reg <= REQ;
        end
        REQ: begin
          if (handshake) begin
            state_reg <= capture ? REQ : IDLE;
          end else if (flush && req_is_load) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem.mem_req_valid = in_req;
  assign mem.mem_req_we    = (req_op_reg == STORE);
  assign mem.mem_req_addr  = req_addr_reg;
  assign mem.mem_req_wdata = req_data_reg;

  inflight_tracker #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .push       (handshake),
    .push_entry (push_entry),
    .pop        (mem.mem_resp_valid),
    .squash_all (flush),
    .head_entry (head_entry),
    .count      (tracker_count),
    .empty      (tracker_empty)
  );

  // A load popped in the same cycle as a flush is squashed along with the rest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_succeeded          <= 1'b0;
      load_succeeded_rob_tag  <= '0;
      load_data               <= '0;
      store_succeeded         <= 1'b0;
      store_succeeded_rob_tag <= '0;
    end else begin
      load_succeeded  <= 1'b0;
      store_succeeded <= 1'b0;
      if (mem.mem_resp_valid && !tracker_empty) begin
        if (head_entry.op == STORE) begin
          store_succeeded         <= 1'b1;
          store_succeeded_rob_tag <= ROB_TAG_WIDTH'(head_entry.rob_tag);
        end else if (is_live_load(head_entry) && !flush) begin
          load_succeeded          <= 1'b1;
          load_succeeded_rob_tag  <= ROB_TAG_WIDTH'(head_entry.rob_tag);
          load_data               <= mem.mem_resp_rdata;
        end
      end
    end
  end

endmodule

// File: doc/memory_request_unit.md
MEMORY_REQUEST_UNIT -- requirements
Module: memory_request_unit

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter ROB_TAG_WIDTH, default 32, ROB tag width.
REQ-003 Parameter MAX_INFLIGHT, default 4, power of two ≥2, outstanding memory ops awaiting response.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 fire_memory_op  input  1  LSU issues op this cycle.
REQ-007 memory_op_type  input  1  0=load, 1=store.
REQ-008 memory_address  input  XLEN  op address.
REQ-009 memory_data  input  XLEN  store data.
REQ-010 memory_rob_tag  input  ROB_TAG_WIDTH  ROB tag of issued op.
REQ-011 kill_mem_req  input  1  cancels the op fired this same cycle.
REQ-012 flush  input  1  squash all in-flight loads (mispredict/exception).
REQ-013 accept  output  1  unit can take an op this cycle.
REQ-014 mem_req_valid, mem_req_we  output  1 each  memory request, write enable.
REQ-015 mem_req_addr, mem_req_wdata  output  XLEN each  request address/data.
REQ-016 mem_req_ready  input  1  memory takes request when valid&&ready.
REQ-017 mem_resp_valid  input  1  in-order response, one per accepted request.
REQ-018 mem_resp_rdata  input  XLEN  load data.
REQ-019 load_succeeded, load_succeeded_rob_tag, load_data  output  1/ROB_TAG_WIDTH/XLEN  load completion to LSU/CDB.
REQ-020 store_succeeded, store_succeeded_rob_tag  output  1/ROB_TAG_WIDTH  store completion to LSU.

Function
REQ-021 Op captured iff fire_memory_op && accept && !kill_mem_req; fire while !accept is ignored.
REQ-022 Captured op held in request register; FSM states IDLE, REQ.
REQ-023 IDLE->REQ on capture; REQ->IDLE on mem_req_valid&&mem_req_ready with no same-cycle capture; REQ->REQ on handshake with same-cycle capture (back-to-back).
REQ-024 mem_req_valid=1 exactly in REQ; request fields stable until handshake.
REQ-025 accept = (state==IDLE || mem_req_ready) && tracker count + (state==REQ) < MAX_INFLIGHT.
REQ-026 On handshake, {type, rob_tag, squashed=0} pushed to circular tracker FIFO (head/tail wrap modulo MAX_INFLIGHT).
REQ-027 On mem_resp_valid, head entry popped; load -> load_succeeded=1, tag, load_data=mem_resp_rdata, registered, one cycle later; store -> store_succeeded=1, tag, one cycle later.
REQ-028 Squashed load popped silently: no load_succeeded pulse.
REQ-029 flush sets squashed on all valid tracker load entries and drops a load in the request register (REQ->IDLE unless handshake occurs same cycle, in which case pushed squashed); stores unaffected (committed).
REQ-030 flush and capture same cycle: captured load dropped, captured store kept.
REQ-031 Push and pop same cycle: count unchanged; pop on empty tracker is a protocol error, ignored.
REQ-032 Response latency unbounded; completion outputs are single-cycle pulses.

Reset
REQ-033 reset low: state=IDLE, tracker empty, head=tail=0, all valid/succeeded outputs 0, tag/data outputs 0, accept=1 after release.
REQ-034 Reset mid-transaction discards all ops; responses arriving after reset with empty tracker ignored.

Structure
REQ-035 Shared lsu package: mem_op_t enum (LOAD, STORE), tracker entry struct {type, rob_tag, squashed}.
REQ-036 One sub-module: inflight_tracker (circular FIFO with count, squash-all port).

Verification
REQ-037 Load tag 5 addr 0x100, ready=1, resp 2 cycles later rdata 0xDEADBEEF -> load_succeeded pulse, tag 5, data 0xDEADBEEF, one cycle after resp.
REQ-038 Fire with kill_mem_req=1 -> mem_req_valid never asserts, no completion.
REQ-039 Four loads, no responses (MAX_INFLIGHT=4) -> accept=0; one response -> accept=1 next cycle.
REQ-040 Load tag 3 in flight, flush, response -> no load_succeeded; following store tag 4 -> store_succeeded tag 4.
REQ-041 mem_req_ready=0 for 3 cycles -> request fields held constant; back-to-back fire on handshake cycle accepted.
REQ-042 reset asserted while REQ with 2 in flight -> all outputs 0 immediately, accept=1 after release.
